// File: rtl/hwpe_ctrl_offloader.sv
// hwpe_ctrl_offloader: drives one job onto an HWPE control slave. It acquires a
// job slot, programs the IO parameter registers, triggers the engine, waits for
// the completion event and reports the acquired job id on the done stream.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | ready for a new job descriptor
//   ACQ      | reading the ACQUIRE register to obtain a job id
//   BACKOFF  | engine was busy; wait RETRY_DELAY cycles before retrying
//   PROG     | writing job register i to the IO register window
//   TRIG     | writing the TRIGGER register
//   WAIT_EVT | waiting for the engine completion event
//   DONE     | presenting the job id on the done stream
module hwpe_ctrl_offloader #(
  parameter int unsigned N_JOB_REGS  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RETRY_DELAY = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [N_JOB_REGS*32-1:0] job_regs_i,
  output logic                    done_valid_o,
  input  logic                    done_ready_i,
  output logic [7:0]              done_id_o,
  output logic                    busy_o,
  output logic                    req_o,
  input  logic                    gnt_i,
  output logic [31:0]             add_o,
  output logic                    wen_o,
  output logic [3:0]              be_o,
  output logic [31:0]             data_o,
  input  logic                    r_valid_i,
  input  logic [31:0]             r_data_i,
  input  logic                    evt_i
);

  localparam int unsigned        IDX_W         = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX      = IDX_W'(N_JOB_REGS - 1);
  localparam logic [7:0]         BACKOFF_LOAD  = 8'(RETRY_DELAY - 1);
  localparam logic [31:0]        ADDR_TRIGGER  = BASE_ADDR + 32'h00;
  localparam logic [31:0]        ADDR_ACQUIRE  = BASE_ADDR + 32'h04;
  localparam logic [31:0]        ADDR_JOB_BASE = BASE_ADDR + 32'h20;

  typedef enum logic [2:0] {
    IDLE, ACQ, BACKOFF, PROG, TRIG, WAIT_EVT, DONE
  } state_e;

  state_e           state_q, state_d;
  logic             outst_q, outst_d;   // a granted transaction awaits its response
  logic             drop_q, drop_d;     // response of an aborted transaction still due
  logic             evt_q, evt_d;       // sticky completion event
  logic [7:0]       bo_cnt_q, bo_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       id_q, id_d;
  logic [31:0]      regs_q [N_JOB_REGS];

  logic             in_xfer_state;
  logic             accept;
  logic             grant;
  logic             rsp;
  logic             unused_rdata;

  // Only the busy flag and the id byte of the ACQUIRE response carry meaning.
  assign unused_rdata = ^r_data_i[30:8];

  assign in_xfer_state = (state_q == ACQ) || (state_q == PROG) || (state_q == TRIG);

  // A new request is only raised once the previous one (including an aborted
  // one) has been answered; clear_i masks it in the same cycle.
  assign req_o  = in_xfer_state && !outst_q && !drop_q && !clear_i;
  assign grant  = req_o && gnt_i;
  assign rsp    = outst_q && r_valid_i;
  assign accept = job_valid_i && job_ready_o && !clear_i;

  assign be_o         = 4'hF;
  assign job_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign done_valid_o = (state_q == DONE);
  assign done_id_o    = id_q;

  // Request payload derives only from state and index, so it stays stable
  // for as long as the request waits for its grant.
  always_comb begin
    add_o  = 32'h0;
    wen_o  = 1'b1;
    data_o = 32'h0;
    case (state_q)
      ACQ: begin
        add_o = ADDR_ACQUIRE;
      end
      PROG: begin
        add_o  = ADDR_JOB_BASE + 32'({idx_q, 2'b00});
        wen_o  = 1'b0;
        data_o = regs_q[idx_q];
      end
      TRIG: begin
        add_o = ADDR_TRIGGER;
        wen_o = 1'b0;
      end
      default: ;
    endcase
  end

  // Next-state, transaction tracking, counters and sticky event.
  always_comb begin
    state_d  = state_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    evt_d    = evt_q;
    bo_cnt_d = bo_cnt_q;
    idx_d    = idx_q;
    id_d     = id_q;

    if (grant) begin
      outst_d = 1'b1;
    end else if (rsp) begin
      outst_d = 1'b0;
    end

    if (drop_q && r_valid_i) begin
      drop_d = 1'b0;
    end

    // The event may arrive as soon as TRIG is granted, before its response.
    if (evt_i && (((state_q == TRIG) && (outst_q || grant)) || (state_q == WAIT_EVT))) begin
      evt_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (job_valid_i) begin
          state_d = ACQ;
        end
      end
      ACQ: begin
        if (rsp) begin
          if (r_data_i[31]) begin
            state_d  = BACKOFF;
            bo_cnt_d = BACKOFF_LOAD;
          end else begin
            state_d = PROG;
            id_d    = r_data_i[7:0];
            idx_d   = '0;
          end
        end
      end
      BACKOFF: begin
        if (bo_cnt_q == 8'd0) begin
          state_d = ACQ;
        end else begin
          bo_cnt_d = bo_cnt_q - 8'd1;
        end
      end
      PROG: begin
        if (rsp) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = TRIG;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      TRIG: begin
        if (rsp) begin
          state_d = WAIT_EVT;
        end
      end
      WAIT_EVT: begin
        if (evt_q || evt_i) begin
          state_d = DONE;
          evt_d   = 1'b0;
        end
      end
      DONE: begin
        if (done_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Soft clear wins over everything. A granted transaction whose response
    // is not arriving right now is remembered so that response is swallowed.
    if (clear_i) begin
      state_d  = IDLE;
      outst_d  = 1'b0;
      drop_d   = (outst_q || drop_q) && !r_valid_i;
      evt_d    = 1'b0;
      bo_cnt_d = 8'd0;
      idx_d    = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      outst_q  <= 1'b0;
      drop_q   <= 1'b0;
      evt_q    <= 1'b0;
      bo_cnt_q <= 8'd0;
      idx_q    <= '0;
      id_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      evt_q    <= evt_d;
      bo_cnt_q <= bo_cnt_d;
      idx_q    <= idx_d;
      id_q     <= id_d;
    end
  end

  // Job descriptor is captured on the accept handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_JOB_REGS; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else if (accept) begin
      for (int i = 0; i < N_JOB_REGS; i++) begin
        regs_q[i] <= job_regs_i[i*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_offloader.sv
// Directed testbench for hwpe_ctrl_offloader with a behavioural control slave.
module tb_hwpe_ctrl_offloader;

  localparam int unsigned N_REGS = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int unsigned RETRY  = 4;

  logic                  clk_i, rst_ni, clear_i;
  logic                  job_valid_i, job_ready_o;
  logic [N_REGS*32-1:0]  job_regs_i;
  logic                  done_valid_o, done_ready_i;
  logic [7:0]            done_id_o;
  logic                  busy_o;
  logic                  req_o, gnt_i, wen_o;
  logic [31:0]           add_o, data_o, r_data_i;
  logic [3:0]            be_o;
  logic                  r_valid_i, evt_i;

  hwpe_ctrl_offloader #(
    .N_JOB_REGS (N_REGS),
    .BASE_ADDR  (BASE),
    .RETRY_DELAY(RETRY)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .job_valid_i (job_valid_i),
    .job_ready_o (job_ready_o),
    .job_regs_i  (job_regs_i),
    .done_valid_o(done_valid_o),
    .done_ready_i(done_ready_i),
    .done_id_o   (done_id_o),
    .busy_o      (busy_o),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .add_o       (add_o),
    .wen_o       (wen_o),
    .be_o        (be_o),
    .data_o      (data_o),
    .r_valid_i   (r_valid_i),
    .r_data_i    (r_data_i),
    .evt_i       (evt_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  // Slave model knobs and records
  int          cyc = 0;
  int          gnt_delay = 0, rsp_extra = 0, wait_cnt = 0;
  bit          out_q = 0, pend = 0, waiting = 0;
  bit          pend_acq = 0, pend_wr = 0, pend_trig = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = 32'h0;
  logic [31:0] held_add = 32'h0, held_dat = 32'h0;
  int          evt_mode = 0;   // 0 none, 1 after TRIG grant, 2 after TRIG response
  int          evt_dly = 1, evt_cnt = 0;
  int          wr_rsp_cnt = 0;
  logic [31:0] acq_q[$];
  logic [31:0] log_add[$];
  logic        log_wen[$];
  logic [31:0] log_dat[$];
  int          acq_start[$];
  int          acq_rsp[$];

  // Control slave: grants after gnt_delay waiting cycles, answers rsp_extra
  // cycles after the cycle following the grant, and drives evt_i.
  initial begin
    gnt_i = 1'b0; r_valid_i = 1'b0; r_data_i = 32'h0; evt_i = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      evt_i = 1'b0;
      if (evt_cnt > 0) begin
        evt_cnt--;
        if (evt_cnt == 0) evt_i = 1'b1;
      end
      if (r_valid_i) begin
        r_valid_i = 1'b0;
        out_q     = 1'b0;
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          r_valid_i = 1'b1;
          r_data_i  = pend_data;
          pend      = 1'b0;
          if (pend_acq) acq_rsp.push_back(cyc);
          if (pend_wr) wr_rsp_cnt++;
          if (pend_trig && evt_mode == 2) evt_cnt = evt_dly;
        end else begin
          pend_cnt--;
        end
      end
      gnt_i = 1'b0;
      if (req_o) begin
        if (out_q) begin
          check_val("one_outstanding", req_o, 1'b0);
        end else begin
          if (!waiting) begin
            waiting  = 1'b1;
            held_add = add_o;
            held_dat = data_o;
            wait_cnt = 0;
            if (wen_o && add_o == BASE + 32'h04) acq_start.push_back(cyc);
          end else begin
            check_val("add_stable", add_o, held_add);
            check_val("data_stable", data_o, held_dat);
          end
          if (wait_cnt == gnt_delay) begin
            gnt_i   = 1'b1;
            out_q   = 1'b1;
            waiting = 1'b0;
            check_val("be", {28'h0, be_o}, 32'hF);
            log_add.push_back(add_o);
            log_wen.push_back(wen_o);
            log_dat.push_back(data_o);
            pend      = 1'b1;
            pend_cnt  = rsp_extra;
            pend_acq  = wen_o && (add_o == BASE + 32'h04);
            pend_wr   = !wen_o && (add_o >= BASE + 32'h20);
            pend_trig = !wen_o && (add_o == BASE);
            pend_data = 32'h0;
            if (pend_acq && acq_q.size() > 0) pend_data = acq_q.pop_front();
            if (pend_trig && evt_mode == 1) evt_cnt = evt_dly;
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        waiting = 1'b0;
      end
    end
  end

  task automatic reset_logs();
    log_add.delete(); log_wen.delete(); log_dat.delete();
    acq_start.delete(); acq_rsp.delete();
    wr_rsp_cnt = 0;
  endtask

  // Expected transaction sequence: n_acq ACQUIRE reads, the job writes, TRIGGER.
  task automatic check_log(input logic [N_REGS*32-1:0] regs, input int n_acq);
    check_val("log_len", log_add.size(), n_acq + N_REGS + 1);
    if (log_add.size() == n_acq + N_REGS + 1) begin
      for (int i = 0; i < n_acq; i++) begin
        check_val("acq_add", log_add[i], BASE + 32'h04);
        check_val("acq_wen", log_wen[i], 1'b1);
      end
      for (int i = 0; i < N_REGS; i++) begin
        check_val("prog_add", log_add[n_acq+i], BASE + 32'h20 + 32'(4*i));
        check_val("prog_wen", log_wen[n_acq+i], 1'b0);
        check_val("prog_dat", log_dat[n_acq+i], regs[i*32 +: 32]);
      end
      check_val("trig_add", log_add[n_acq+N_REGS], BASE);
      check_val("trig_wen", log_wen[n_acq+N_REGS], 1'b0);
      check_val("trig_dat", log_dat[n_acq+N_REGS], 32'h0);
    end
  endtask

  // Submit one job, wait for done, optionally stall done_ready, then handshake.
  // lat counts cycles from the accept cycle (cycle 0) to the first done cycle.
  task automatic run_job(input logic [N_REGS*32-1:0] regs, input int stall,
                         input logic [7:0] exp_id, output int lat);
    @(negedge clk_i);
    check_val("job_ready_idle", job_ready_o, 1'b1);
    job_regs_i  = regs;
    job_valid_i = 1'b1;
    @(negedge clk_i);
    job_valid_i = 1'b0;
    lat = 1;
    while (!done_valid_o && lat < 2000) begin
      @(negedge clk_i);
      lat++;
    end
    check_val("done_reached", done_valid_o, 1'b1);
    check_val("done_id", done_id_o, exp_id);
    check_val("job_ready_in_done", job_ready_o, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_i);
      check_val("stall_valid", done_valid_o, 1'b1);
      check_val("stall_id", done_id_o, exp_id);
      check_val("stall_job_ready", job_ready_o, 1'b0);
    end
    done_ready_i = 1'b1;
    @(negedge clk_i);
    done_ready_i = 1'b0;
    check_val("post_done_valid", done_valid_o, 1'b0);
    check_val("post_job_ready", job_ready_o, 1'b1);
    check_val("post_busy", busy_o, 1'b0);
  endtask

  logic [N_REGS*32-1:0] regs_a, regs_b, regs_c;
  int lat, n;

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; job_valid_i = 1'b0; done_ready_i = 1'b0;
    job_regs_i = '0;
    regs_a = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    regs_b = {32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
    regs_c = {32'h0BAD_F00D, 32'hCAFE_BABE, 32'h5555_AAAA, 32'h0000_0010};
    repeat (3) @(negedge clk_i);
    check_val("rst_req", req_o, 1'b0);
    check_val("rst_add", add_o, 32'h0);
    check_val("rst_wen", wen_o, 1'b1);
    check_val("rst_be", {28'h0, be_o}, 32'hF);
    check_val("rst_data", data_o, 32'h0);
    check_val("rst_job_ready", job_ready_o, 1'b1);
    check_val("rst_done_valid", done_valid_o, 1'b0);
    check_val("rst_done_id", done_id_o, 8'h00);
    check_val("rst_busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Nominal: event 10 cycles after TRIG response -> 12 + 1 + 10 cycles.
    reset_logs(); acq_q.push_back(32'h3);
    gnt_delay = 0; rsp_extra = 0; evt_mode = 2; evt_dly = 10;
    run_job(regs_a, 0, 8'h03, lat);
    check_log(regs_a, 1);
    check_val("nominal_lat", lat, 23);

    // Busy engine: two busy reads then id 1; RETRY cycles idle between tries.
    reset_logs();
    acq_q.push_back(32'hFFFF_FFFF); acq_q.push_back(32'hFFFF_FFFF); acq_q.push_back(32'h1);
    evt_mode = 1; evt_dly = 1;
    run_job(regs_b, 0, 8'h01, lat);
    check_log(regs_b, 3);
    check_val("busy_n_start", acq_start.size(), 3);
    check_val("busy_n_rsp", acq_rsp.size(), 3);
    if (acq_start.size() == 3 && acq_rsp.size() == 3) begin
      check_val("retry_gap0", acq_start[1] - acq_rsp[0] - 1, RETRY);
      check_val("retry_gap1", acq_start[2] - acq_rsp[1] - 1, RETRY);
    end

    // Backpressure: grant 3 cycles after request; payload stability checked by the slave.
    reset_logs(); acq_q.push_back(32'h10);
    gnt_delay = 3;
    run_job(regs_c, 0, 8'h10, lat);
    check_log(regs_c, 1);
    gnt_delay = 0;

    // Early event: pulse right after TRIG grant while its response is delayed.
    reset_logs(); acq_q.push_back(32'h7);
    rsp_extra = 3; evt_mode = 1; evt_dly = 1;
    run_job(regs_a, 0, 8'h07, lat);
    check_log(regs_a, 1);
    rsp_extra = 0;

    // Minimum latency with done stall; bit 31 clear, upper bits ignored for the id.
    reset_logs(); acq_q.push_back(32'h7FFF_FF42);
    run_job(regs_b, 5, 8'h42, lat);
    check_val("min_latency", lat, 2 * (N_REGS + 2) + 2);

    // Abort during PROG with the third write granted and its response late.
    reset_logs(); acq_q.push_back(32'h2);
    rsp_extra = 5; evt_mode = 0;
    @(negedge clk_i);
    job_regs_i = regs_c; job_valid_i = 1'b1;
    @(negedge clk_i);
    job_valid_i = 1'b0;
    n = 0;
    while (!(wr_rsp_cnt == 2 && pend) && n < 500) begin
      @(posedge clk_i); #1; n++;
    end
    check_val("abort_reached", n < 500, 1'b1);
    clear_i = 1'b1;
    #1;
    check_val("abort_req_low", req_o, 1'b0);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    check_val("abort_busy", busy_o, 1'b0);
    check_val("abort_job_ready", job_ready_o, 1'b1);
    check_val("abort_done_valid", done_valid_o, 1'b0);
    rsp_extra = 0;
    // Next job starts while the stale response is still due.
    reset_logs(); acq_q.push_back(32'h5); evt_mode = 1; evt_dly = 1;
    run_job(regs_b, 0, 8'h05, lat);
    check_log(regs_b, 1);

    // Clear while a request is waiting for its grant: req_o drops at once.
    reset_logs(); acq_q.delete(); acq_q.push_back(32'h9);
    gnt_delay = 5;
    @(negedge clk_i);
    job_regs_i = regs_a; job_valid_i = 1'b1;
    @(posedge clk_i); #1;
    job_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check_val("clr_req_before", req_o, 1'b1);
    clear_i = 1'b1;
    #1;
    check_val("clr_req_gated", req_o, 1'b0);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    check_val("clr_busy", busy_o, 1'b0);
    check_val("clr_req_after", req_o, 1'b0);
    check_val("clr_n_grants", log_add.size(), 0);
    gnt_delay = 0; acq_q.delete();

    // Reset in the middle of a granted transaction, then a stray response.
    reset_logs(); acq_q.push_back(32'h0C); rsp_extra = 5;
    @(negedge clk_i);
    job_regs_i = regs_c; job_valid_i = 1'b1;
    @(negedge clk_i);
    job_valid_i = 1'b0;
    n = 0;
    while (!pend && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    check_val("rst_mid_reached", n < 100, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_val("rst_mid_busy", busy_o, 1'b0);
    check_val("rst_mid_req", req_o, 1'b0);
    check_val("rst_mid_job_ready", job_ready_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    check_val("stray_rsp_busy", busy_o, 1'b0);
    check_val("stray_rsp_req", req_o, 1'b0);
    rsp_extra = 0;
    reset_logs(); acq_q.delete(); acq_q.push_back(32'h0C);
    run_job(regs_c, 0, 8'h0C, lat);
    check_log(regs_c, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_ctrl_offloader.md
HWPE_CTRL_OFFLOADER -- requirements
Module: hwpe_ctrl_offloader

Interface
REQ-001 SHALL have parameter N_JOB_REGS, default 4, number of IO parameter registers programmed per job (1..48).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address of the target HWPE control register file.
REQ-003 SHALL have parameter RETRY_DELAY, default 4, idle cycles between a busy ACQUIRE read and the next retry (>=1).
REQ-004 SHALL have ports: clk_i  in  1  clock, single clock domain; all flops rising-edge.
REQ-005 SHALL have ports: rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 clear_i  in  1  synchronous soft clear.
REQ-007 job_valid_i  in  1 / job_ready_o  out  1 / job_regs_i  in  N_JOB_REGS x 32  job descriptor stream.
REQ-008 done_valid_o  out  1 / done_ready_i  in  1 / done_id_o  out  8  completion stream, carries acquired job id.
REQ-009 busy_o  out  1  high in every state except IDLE.
REQ-010 req_o  out  1 / gnt_i  in  1 / add_o  out  32 / wen_o  out  1 (1=read, 0=write) / be_o  out  4 / data_o  out  32  peripheral request channel toward the HWPE control slave.
REQ-011 r_valid_i  in  1 / r_data_i  in  32  peripheral response channel.
REQ-012 evt_i  in  1  completion event from the HWPE (single-cycle pulse).

Function
REQ-013 SHALL implement FSM states IDLE, ACQ, BACKOFF, PROG, TRIG, WAIT_EVT, DONE.
REQ-014 job_ready_o SHALL be high only in IDLE; on job_valid_i && job_ready_o, job_regs_i SHALL be latched and FSM SHALL enter ACQ next cycle.
REQ-015 Request rule: req_o asserted with add_o/wen_o/be_o/data_o stable until the cycle gnt_i is high; be_o always 4'hF.
REQ-016 At most one outstanding transaction: after a grant, req_o SHALL stay low until r_valid_i (for reads and writes); req_o may reassert the cycle after r_valid_i.
REQ-017 ACQ: read at BASE_ADDR+32'h04; on r_valid_i, r_data_i[31]=1 -> BACKOFF; else latch r_data_i[7:0] as job id -> PROG.
REQ-018 BACKOFF: 8-bit counter counts RETRY_DELAY cycles with req_o low, then returns to ACQ; retries unbounded.
REQ-019 PROG: write job_regs_i[i] to BASE_ADDR+32'h20+4*i for i=0..N_JOB_REGS-1 in ascending order; index counter advances on each r_valid_i; after last r_valid_i -> TRIG.
REQ-020 TRIG: write 32'h0 to BASE_ADDR+32'h00; on r_valid_i -> WAIT_EVT.
REQ-021 A sticky evt flag SHALL be set by evt_i from the TRIG grant cycle onward (covers an event arriving before TRIG's r_valid_i); evt_i outside TRIG/WAIT_EVT SHALL be ignored.
REQ-022 WAIT_EVT: when sticky flag or evt_i is high -> DONE next cycle; flag cleared on leaving WAIT_EVT.
REQ-023 DONE: done_valid_o=1, done_id_o=latched id, held stable until done_ready_i; on handshake -> IDLE.
REQ-024 r_valid_i while no transaction is outstanding SHALL be ignored.
REQ-025 clear_i SHALL force IDLE next cycle from any state, drop req_o immediately (combinationally gated), clear counters and sticky flag, and discard the response of any aborted granted transaction; clear_i has priority over all other events in the same cycle.
REQ-026 Latency minimum (gnt_i and r_valid_i tied so each transaction takes 2 cycles, no backoff): job accept to done_valid_o = 2*(N_JOB_REGS+2)+2 cycles.

Reset
REQ-027 On rst_ni low: state IDLE, req_o=0, add_o=0, wen_o=1, be_o=4'hF, data_o=0, job_ready_o=1, done_valid_o=0, done_id_o=0, busy_o=0, counters and sticky flag 0, latched job registers 0.
REQ-028 Reset assertion mid-transaction SHALL abort it without waiting for r_valid_i.

Verification
REQ-029 Nominal: N_JOB_REGS=4, ACQUIRE returns 32'h3, evt_i 10 cycles after TRIG response -> writes to 0x20,0x24,0x28,0x2C, then 0x00 data 0; done_id_o=8'h03.
REQ-030 Busy: ACQUIRE returns 32'hFFFF_FFFF twice then 32'h1 -> three reads at 0x04, each retry exactly RETRY_DELAY=4 cycles of req_o low; done_id_o=8'h01.
REQ-031 Backpressure: gnt_i delayed 3 cycles per request -> add_o/data_o stable during wait; no second req_o before r_valid_i.
REQ-032 Early event: evt_i pulses one cycle after TRIG grant, before its r_valid_i -> done_valid_o still asserted, no hang.
REQ-033 Abort: clear_i during PROG after 2 writes -> req_o low same cycle, IDLE next cycle, late r_valid_i ignored, next job starts cleanly at ACQ.
REQ-034 Done stall: done_ready_i low 5 cycles -> done_valid_o/done_id_o held, job_ready_o low until handshake.
